toggle_monitor: RTL
===================

Name: toggle_monitor

Overview:
- Downstream consumer and checker for the T flip-flop stage.
- Samples the flip-flop output q and the toggle command t that drove it.
- Counts toggles and flags every cycle where q did not follow the T rule (q_next = q ^ t).
- Raises a sticky fault after a programmable number of mismatches; intended for bring-up benches and in-system health monitoring.

Parameters:
- CNT_W, 16, width of toggle counter.
- ERR_W, 8, width of mismatch counter.
- ERR_LIMIT, 4, mismatch count at which fault asserts; legal range 1 to 2^ERR_W-1.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  monitor enable; 0 returns FSM to IDLE, counters hold.
- clr  input  1  synchronous clear of counters, fault and FSM (to IDLE); ignored while reset=0.
- q_in  input  1  q of the monitored T flip-flop.
- t_in  input  1  t applied to the monitored T flip-flop, same cycle as q_in.
- toggle_pulse  output  1  one-cycle pulse when q_in changed versus previous sample (CHECK only).
- mismatch  output  1  one-cycle pulse when q_in differs from expected value.
- toggle_cnt  output  CNT_W  toggles seen, saturating at 2^CNT_W-1.
- err_cnt  output  ERR_W  mismatches seen, saturating at 2^ERR_W-1.
- fault  output  1  sticky; set when err_cnt reaches ERR_LIMIT.
- state  output  2  FSM state: IDLE=0, SYNC=1, CHECK=2, FAULT=3.

Behaviour:
- Reset (reset=0 at rising clk):
  - state=IDLE; toggle_pulse=0, mismatch=0, toggle_cnt=0, err_cnt=0, fault=0.
  - Internal q_prev=0, t_prev=0.
  - Reset has priority over clr and en; reset mid-run discards everything.
- Sampling registers q_prev<=q_in and t_prev<=t_in every cycle while en=1 and not in IDLE.
- Expected value: exp = q_prev ^ t_prev. The flip-flop sampled t_prev at the same edge the monitor did, so its effect is visible one cycle later.
- FSM:
  - IDLE: en=1 -> SYNC, capturing q_in/t_in; no check this cycle.
  - SYNC: captures samples; -> CHECK next cycle if en=1, else IDLE.
  - CHECK: each cycle compares q_in with exp.
    - mismatch pulses the cycle after the offending sample is registered (latency 1).
    - err_cnt increments.
    - If the new err_cnt equals ERR_LIMIT: fault<=1, -> FAULT.
    - en=0 -> IDLE.
  - FAULT: fault held; counters frozen; toggle_pulse and mismatch held 0. Exit only via clr (-> IDLE) or reset.
- toggle_pulse: registered, asserted the cycle after a CHECK sample where q_in != q_prev. toggle_cnt increments on the same condition.
- Saturation: toggle_cnt and err_cnt stop at all-ones, never wrap.
- clr:
  - Zeroes counters and fault, forces IDLE, drops pulses the next cycle.
  - clr with en=1 in the same cycle: clr wins; SYNC is entered the following cycle.
- en deasserted mid-CHECK: counters and fault hold their values; re-enable goes through SYNC again, so there is no false mismatch from stale q_prev.
- Toggle and mismatch in the same cycle are both counted.
- An X on q_in is not filtered; a mismatch is flagged.

Optional Feature:
- Macro TOGGLE_MONITOR_EDGE_SPLIT_EN.
- Defined:
  - Adds outputs rise_cnt and fall_cnt, each CNT_W wide, saturating.
  - They count 0->1 and 1->0 toggles separately under the toggle_cnt rules, and reset and clear with toggle_cnt.
  - Invariant before saturation: rise_cnt+fall_cnt = toggle_cnt.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package toggle_monitor_pkg holds:
  - the state encoding constants/typedef (IDLE, SYNC, CHECK, FAULT);
  - default CNT_W/ERR_W/ERR_LIMIT;
  - a saturating-increment function.
- One sub-module, toggle_edge_det: registers q_in and emits rise, fall and any-edge strobes. Instantiated once.
- FSM and counters stay in the top.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with en=1, q_in toggling -> all outputs 0, state=0.
- Clean divide-by-2: en=1, t_in=1 constant, q_in correctly toggling every cycle for 20 cycles -> toggle_cnt=18 (SYNC skips first), err_cnt=0, mismatch never high.
- Hold: t_in=0, q_in held 1 for 10 cycles -> toggle_cnt=0, err_cnt=0.
- Fault injection with ERR_LIMIT=4: force q_in stuck at 0 while t_in=1 -> mismatch pulses 4 times, err_cnt=4, fault=1, state=3; counters frozen for the next 10 cycles.
- clr from FAULT: pulse clr 1 cycle -> next cycle fault=0, err_cnt=0, toggle_cnt=0, state=0. Raising en then gives SYNC, then CHECK.
- Saturation with CNT_W=4: 20 correct toggles -> toggle_cnt=15, held. With TOGGLE_MONITOR_EDGE_SPLIT_EN defined, rise_cnt/fall_cnt track their edge counts and saturate at 15 without wrapping.

Source files
------------

// File: rtl/toggle_monitor_pkg.sv
// Shared state encoding, default sizing and saturating arithmetic for toggle_monitor.
package toggle_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    FAULT = 2'd3
  } tm_state_e;

  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned ERR_W_DEF     = 8;
  localparam int unsigned ERR_LIMIT_DEF = 4;

  // Increment v, holding at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/toggle_monitor_edge_det.sv
// Holds the previous sample of the monitored q and decodes rise/fall/any-edge strobes.
module toggle_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic d,
  output logic d_prev,
  output logic rise,
  output logic fall,
  output logic edge_any
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_prev <= 1'b0;
    end else if (sample_en) begin
      d_prev <= d;
    end
  end

  assign rise     = d & ~d_prev;
  assign fall     = ~d & d_prev;
  assign edge_any = d ^ d_prev;

endmodule

// File: rtl/toggle_monitor.sv
// Checks a T flip-flop against q_next = q ^ t, counts toggles/mismatches, latches a fault.
// Build option TOGGLE_MONITOR_EDGE_SPLIT_EN adds separate rise_cnt/fall_cnt outputs.
//
// state | meaning
// IDLE  | disabled or just cleared; waiting for en
// SYNC  | first sample captured, nothing to compare against yet
// CHECK | comparing every sample with the previous q ^ t
// FAULT | mismatch limit reached; frozen until clr or reset
module toggle_monitor
  import toggle_monitor_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned ERR_W     = ERR_W_DEF,
  parameter int unsigned ERR_LIMIT = ERR_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             q_in,
  input  logic             t_in,
  output logic             toggle_pulse,
  output logic             mismatch,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fault,
  output logic [1:0]       state
`ifdef TOGGLE_MONITOR_EDGE_SPLIT_EN
  ,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt
`endif
);

  tm_state_e  st_q, st_d;
  logic       sample_en;
  logic       q_prev, t_prev;
  logic       q_rise, q_fall, q_edge;
  logic       exp_q, mis_now, chk, hit_limit;
  logic [ERR_W-1:0] err_next;

  assign sample_en = en & ~clr & (st_q != FAULT);

  toggle_edge_det u_edge (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .d        (q_in),
    .d_prev   (q_prev),
    .rise     (q_rise),
    .fall     (q_fall),
    .edge_any (q_edge)
  );

  // The flop consumed t_prev on the edge we sampled it, so its effect shows now.
  assign exp_q     = q_prev ^ t_prev;
  assign mis_now   = (q_in !== exp_q);
  assign err_next  = ERR_W'(sat_inc(32'(err_cnt), ERR_W));
  assign hit_limit = (err_next == ERR_W'(ERR_LIMIT));

  always_comb begin
    st_d = st_q;
    chk  = 1'b0;
    case (st_q)
      IDLE:  if (en) st_d = SYNC;
      SYNC:  st_d = en ? CHECK : IDLE;
      CHECK: begin
        if (!en) begin
          st_d = IDLE;
        end else begin
          chk = 1'b1;
          if (mis_now && hit_limit) st_d = FAULT;
        end
      end
      FAULT: st_d = FAULT;
      default: st_d = IDLE;
    endcase
    if (clr) st_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q         <= IDLE;
      t_prev       <= 1'b0;
      toggle_pulse <= 1'b0;
      mismatch     <= 1'b0;
      toggle_cnt   <= '0;
      err_cnt      <= '0;
      fault        <= 1'b0;
    end else if (clr) begin
      st_q         <= IDLE;
      toggle_pulse <= 1'b0;
      mismatch     <= 1'b0;
      toggle_cnt   <= '0;
      err_cnt      <= '0;
      fault        <= 1'b0;
    end else begin
      st_q         <= st_d;
      toggle_pulse <= chk & q_edge;
      mismatch     <= chk & mis_now;
      if (sample_en) t_prev <= t_in;
      if (chk && q_edge) toggle_cnt <= CNT_W'(sat_inc(32'(toggle_cnt), CNT_W));
      if (chk && mis_now) begin
        err_cnt <= err_next;
        if (hit_limit) fault <= 1'b1;
      end
    end
  end

  assign state = st_q;

`ifdef TOGGLE_MONITOR_EDGE_SPLIT_EN
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else if (chk) begin
      if (q_rise) rise_cnt <= CNT_W'(sat_inc(32'(rise_cnt), CNT_W));
      if (q_fall) fall_cnt <= CNT_W'(sat_inc(32'(fall_cnt), CNT_W));
    end
  end
`else
  logic unused_edges;
  assign unused_edges = q_rise ^ q_fall;
`endif

endmodule
